beta_mem_arbiter: RTL and testbench



---
 rtl/beta_pkg.sv | 22 ++
 rtl/beta_arb_starve_cnt.sv | 33 +++
 rtl/beta_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_beta_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// Shared types for the beta memory arbiter: FSM state, grant encoding, helpers.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package beta_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_e;

  // Counter width able to hold 0..limit inclusive (at least one bit).
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/beta_arb_starve_cnt.sv
// Saturating count of consecutive arbitrations fetch lost while pending.
// Latency: at_limit_o reflects the count registered on the previous edge.
// Backpressure: none; inc_i/clr_i are single-cycle strobes from the arbiter.
module beta_arb_starve_cnt #(
  parameter int StarveLimit = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);
  import beta_pkg::*;

  localparam int CntWidth = starve_cnt_width(StarveLimit);
  localparam logic [CntWidth-1:0] Limit = CntWidth'(StarveLimit);

  logic [CntWidth-1:0] cnt_q;

  // Clear wins over increment; increment stops at the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != Limit)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_limit_o = (cnt_q == Limit);

endmodule

// File: rtl/beta_mem_arbiter.sv
// Arbitrates fetch and LSU requesters onto one memory bus, one transaction at a time.
// Latency: request to mem_req_o 1 cycle; ready/valid pulses combinational from mem_ready_i/mem_valid_i.
// Backpressure: requests wait in IDLE while a transaction is outstanding; memory stalls hold ISSUE.
module beta_mem_arbiter #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int StarveLimit  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_req_i,
  input  logic [AddressWidth-1:0]  i_addr_i,
  output logic                     i_ready_o,
  output logic                     i_valid_o,
  input  logic                     d_req_i,
  input  logic                     d_we_i,
  input  logic [AddressWidth-1:0]  d_addr_i,
  input  logic [DataWidth-1:0]     d_wdata_i,
  input  logic [DataWidth/8-1:0]   d_strb_i,
  output logic                     d_ready_o,
  output logic                     d_valid_o,
  output logic [DataWidth-1:0]     rdata_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [AddressWidth-1:0]  mem_addr_o,
  output logic [DataWidth-1:0]     mem_wdata_o,
  output logic [DataWidth/8-1:0]   mem_strb_o,
  input  logic                     mem_ready_i,
  input  logic                     mem_valid_i,
  input  logic [DataWidth-1:0]     mem_rdata_i
);
  import beta_pkg::*;

  localparam int StrbWidth = DataWidth / 8;

  arb_state_e             state_q;
  arb_state_e             state_d;
  gnt_e                   gnt_q;
  logic                   we_q;
  logic [AddressWidth-1:0] addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   strb_q;

  logic arb_go;
  logic fetch_wins;
  logic starve_at_limit;
  logic starve_inc;
  logic starve_clr;

  // Arbitration happens only in IDLE; data has priority unless fetch has starved.
  assign arb_go     = (state_q == ARB_IDLE) && (i_req_i || d_req_i);
  assign fetch_wins = i_req_i && (!d_req_i || starve_at_limit);
  assign starve_inc = arb_go && !fetch_wins && i_req_i;
  assign starve_clr = arb_go && (fetch_wins || !i_req_i);

  beta_arb_starve_cnt #(
    .StarveLimit (StarveLimit)
  ) u_starve_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (starve_inc),
    .clr_i      (starve_clr),
    .at_limit_o (starve_at_limit)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> ISSUE on a request, ISSUE -> WAIT on accept, WAIT -> IDLE on response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (arb_go)      state_d = ARB_ISSUE;
      ARB_ISSUE: if (mem_ready_i) state_d = ARB_WAIT;
      ARB_WAIT:  if (mem_valid_i) state_d = ARB_IDLE;
      default:                    state_d = ARB_IDLE;
    endcase
  end

  // Grant and payload captured once at arbitration, frozen until the next arbitration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q   <= GNT_FETCH;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (arb_go) begin
      if (fetch_wins) begin
        gnt_q   <= GNT_FETCH;
        we_q    <= 1'b0;
        addr_q  <= i_addr_i;
        wdata_q <= '0;
        strb_q  <= '1;
      end else begin
        gnt_q   <= GNT_DATA;
        we_q    <= d_we_i;
        addr_q  <= d_addr_i;
        wdata_q <= d_wdata_i;
        strb_q  <= d_strb_i;
      end
    end
  end

  // Outputs decoded from state; everything is forced low while reset is asserted.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    i_ready_o   = 1'b0;
    d_ready_o   = 1'b0;
    i_valid_o   = 1'b0;
    d_valid_o   = 1'b0;
    rdata_o     = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;
    if (!rst_i) begin
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
      mem_strb_o  = strb_q;
      case (state_q)
        ARB_ISSUE: begin
          mem_req_o = 1'b1;
          mem_we_o  = (gnt_q == GNT_DATA) && we_q;
          i_ready_o = mem_ready_i && (gnt_q == GNT_FETCH);
          d_ready_o = mem_ready_i && (gnt_q == GNT_DATA);
        end
        ARB_WAIT: begin
          rdata_o   = mem_rdata_i;
          i_valid_o = mem_valid_i && (gnt_q == GNT_FETCH);
          d_valid_o = mem_valid_i && (gnt_q == GNT_DATA);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Self-checking bench for beta_mem_arbiter: directed scenarios then randomized traffic.
// Latency: each step is one clock; outputs sampled shortly after the falling edge.
// Backpressure: bench requesters hold requests until the expected ready pulse.
module tb_beta_mem_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LIM = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          i_req_i;
  logic [AW-1:0] i_addr_i;
  logic          i_ready_o;
  logic          i_valid_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [3:0]    d_strb_i;
  logic          d_ready_o;
  logic          d_valid_o;
  logic [DW-1:0] rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_strb_o;
  logic          mem_ready_i;
  logic          mem_valid_i;
  logic [DW-1:0] mem_rdata_i;

  always #5 clk_i = ~clk_i;

  beta_mem_arbiter #(
    .DataWidth    (DW),
    .AddressWidth (AW),
    .StarveLimit  (LIM)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_req_i     (i_req_i),
    .i_addr_i    (i_addr_i),
    .i_ready_o   (i_ready_o),
    .i_valid_o   (i_valid_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_strb_i    (d_strb_i),
    .d_ready_o   (d_ready_o),
    .d_valid_o   (d_valid_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_strb_o  (mem_strb_o),
    .mem_ready_i (mem_ready_i),
    .mem_valid_i (mem_valid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference: is a transaction open, has memory accepted it,
  // who owns it, and what payload was captured.
  bit            m_busy;
  bit            m_acc;
  bit            m_fetch;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_strb;
  int            m_starve;

  bit e_i_ready, e_d_ready, e_i_valid, e_d_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_acc    = 1'b0;
    m_fetch  = 1'b1;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_strb   = '0;
    m_starve = 0;
  endtask

  // Called at a falling edge with inputs already applied; checks, advances the
  // model across the next rising edge and returns at the following falling edge.
  task automatic step();
    bit issue;
    bit waiting;
    bit fw;
    #1;
    issue     = !rst_i && m_busy && !m_acc;
    waiting   = !rst_i && m_busy && m_acc;
    e_i_ready = issue && mem_ready_i && m_fetch;
    e_d_ready = issue && mem_ready_i && !m_fetch;
    e_i_valid = waiting && mem_valid_i && m_fetch;
    e_d_valid = waiting && mem_valid_i && !m_fetch;
    chk("mem_req",   32'(mem_req_o),   32'(issue));
    chk("mem_we",    32'(mem_we_o),    32'(issue && m_we));
    chk("i_ready",   32'(i_ready_o),   32'(e_i_ready));
    chk("d_ready",   32'(d_ready_o),   32'(e_d_ready));
    chk("i_valid",   32'(i_valid_o),   32'(e_i_valid));
    chk("d_valid",   32'(d_valid_o),   32'(e_d_valid));
    chk("mem_addr",  mem_addr_o,       rst_i ? 32'd0 : m_addr);
    chk("mem_wdata", mem_wdata_o,      rst_i ? 32'd0 : m_wdata);
    chk("mem_strb",  32'(mem_strb_o),  rst_i ? 32'd0 : 32'(m_strb));
    if (e_i_valid || e_d_valid) chk("rdata", rdata_o, mem_rdata_i);

    if (rst_i) begin
      model_reset();
    end else if (!m_busy) begin
      if (i_req_i || d_req_i) begin
        fw = i_req_i && (!d_req_i || m_starve == LIM);
        m_busy  = 1'b1;
        m_acc   = 1'b0;
        m_fetch = fw;
        if (fw) begin
          m_we = 1'b0; m_addr = i_addr_i; m_wdata = '0; m_strb = 4'hF;
          m_starve = 0;
        end else begin
          m_we = d_we_i; m_addr = d_addr_i; m_wdata = d_wdata_i; m_strb = d_strb_i;
          if (i_req_i) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
          else         m_starve = 0;
        end
      end
    end else if (!m_acc) begin
      if (mem_ready_i) m_acc = 1'b1;
    end else if (mem_valid_i) begin
      m_busy = 1'b0;
    end
    @(negedge clk_i);
  endtask

  initial begin
    int  n_data;
    bit  seen_fetch;
    bit  ir, dr;
    logic [31:0] r;

    rst_i = 1'b1; i_req_i = 1'b0; i_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_strb_i = '0;
    mem_ready_i = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = '0;
    model_reset();
    @(negedge clk_i);
    step();
    step();
    rst_i = 1'b0;
    #1 chk("reset_rdata", rdata_o, 32'd0);
    step();

    // Fetch only: accept at cycle 2, respond at cycle 4.
    i_req_i = 1'b1; i_addr_i = 32'h100;
    step();                                     // cycle 0: arbitrate
    step();                                     // cycle 1: ISSUE, no accept
    mem_ready_i = 1'b1;
    #1 chk("fetch_i_ready_c2", 32'(i_ready_o), 32'd1);
    chk("fetch_addr_c2", mem_addr_o, 32'h100);
    step();                                     // cycle 2: accepted
    i_req_i = 1'b0; mem_ready_i = 1'b0;
    step();                                     // cycle 3: WAIT
    mem_valid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    #1 chk("fetch_i_valid_c4", 32'(i_valid_o), 32'd1);
    chk("fetch_rdata_c4", rdata_o, 32'h0000_0013);
    step();                                     // cycle 4: response
    mem_valid_i = 1'b0;
    step();

    // Simultaneous fetch and data write: write goes first.
    i_req_i = 1'b1; i_addr_i = 32'h200;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h80; d_wdata_i = 32'hDEAD_BEEF; d_strb_i = 4'hF;
    step();
    mem_ready_i = 1'b1;
    #1 chk("both_first_addr", mem_addr_o, 32'h80);
    chk("both_first_we", 32'(mem_we_o), 32'd1);
    chk("both_first_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("both_no_i_ready", 32'(i_ready_o), 32'd0);
    step();
    d_req_i = 1'b0; mem_ready_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 32'h0;
    #1 chk("both_d_valid", 32'(d_valid_o), 32'd1);
    step();
    mem_valid_i = 1'b0;
    step();                                     // IDLE: fetch arbitrated
    #1 chk("both_second_addr", mem_addr_o, 32'h200);
    chk("both_second_we", 32'(mem_we_o), 32'd0);
    mem_ready_i = 1'b1;
    step();
    i_req_i = 1'b0; mem_ready_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    step();
    mem_valid_i = 1'b0;
    step();

    // Starvation: data keeps requesting, fetch pending; fetch wins the fifth arbitration.
    i_req_i = 1'b1; i_addr_i = 32'h300;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40; d_strb_i = 4'hF;
    mem_ready_i = 1'b1; mem_valid_i = 1'b1; mem_rdata_i = 32'hCAFE_0000;
    n_data = 0; seen_fetch = 1'b0;
    for (int c = 0; c < 60 && !seen_fetch; c++) begin
      #1;
      ir = i_ready_o; dr = d_ready_o;
      step();
      if (dr) n_data++;
      if (ir) begin seen_fetch = 1'b1; i_req_i = 1'b0; d_req_i = 1'b0; end
    end
    chk("starve_fetch_granted", 32'(seen_fetch), 32'd1);
    chk("starve_data_wins", n_data, 32'(LIM));
    step();                                     // WAIT: response
    mem_ready_i = 1'b0; mem_valid_i = 1'b0;
    step();

    // Memory stalls acceptance for 3 cycles.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h44; d_strb_i = 4'h3;
    step();
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_no_d_ready", 32'(d_ready_o), 32'd0);
      chk("stall_req", 32'(mem_req_o), 32'd1);
      chk("stall_addr", mem_addr_o, 32'h44);
      step();
    end
    mem_ready_i = 1'b1;
    #1 chk("stall_d_ready", 32'(d_ready_o), 32'd1);
    step();
    d_req_i = 1'b0; mem_ready_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
    step();
    mem_valid_i = 1'b0;
    step();

    // Reset while waiting for a response; the late response must be ignored.
    i_req_i = 1'b1; i_addr_i = 32'h500;
    step();
    mem_ready_i = 1'b1;
    step();
    i_req_i = 1'b0; mem_ready_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 32'h0;
    #1 chk("rst_no_i_valid", 32'(i_valid_o), 32'd0);
    chk("rst_req_low", 32'(mem_req_o), 32'd0);
    chk("rst_addr_zero", mem_addr_o, 32'd0);
    chk("rst_rdata_zero", rdata_o, 32'd0);
    step();
    mem_valid_i = 1'b0;
    step();

    // Response strobe during ISSUE is ignored.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h60; d_wdata_i = 32'h5555_AAAA; d_strb_i = 4'h5;
    step();
    mem_valid_i = 1'b1;
    #1 chk("issue_no_d_valid", 32'(d_valid_o), 32'd0);
    step();
    mem_valid_i = 1'b0; mem_ready_i = 1'b1;
    step();
    d_req_i = 1'b0; mem_ready_i = 1'b0; mem_valid_i = 1'b1;
    #1 chk("issue_d_valid_later", 32'(d_valid_o), 32'd1);
    step();
    mem_valid_i = 1'b0;
    step();

    // Randomized traffic; requesters scramble payload once accepted.
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      if (!i_req_i && $urandom_range(0, 2) == 0) begin
        i_req_i = 1'b1; r = $urandom; i_addr_i = r & 32'hFFFF_FFFC;
      end
      if (!d_req_i && $urandom_range(0, 2) == 0) begin
        d_req_i = 1'b1; d_we_i = $urandom_range(0, 1);
        d_addr_i = $urandom; d_wdata_i = $urandom; r = $urandom; d_strb_i = r[3:0];
      end
      mem_ready_i = $urandom_range(0, 1);
      mem_valid_i = $urandom_range(0, 1);
      mem_rdata_i = $urandom;
      step();
      if (e_i_ready) begin i_req_i = 1'b0; i_addr_i = $urandom; end
      if (e_d_ready) begin d_req_i = 1'b0; d_addr_i = $urandom; d_wdata_i = $urandom; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
